suprloco_rom_loader: RTL

- Sits between the HPS ioctl download stream and the SuprLoco game board.
- Decodes each downloaded byte into a ROM region (main CPU, sound CPU, tiles, sprites, colour PROM) and issues a held request/acknowledge write to the board's ROM write port.
- Back-pressures the HPS through ioctl_wait while a write is pending.
- Captures DIP switch bytes, holds the board in reset during and shortly after a download, and reports load completion or size errors.

---
 rtl/suprloco_loader_pkg.sv | 27 ++
 rtl/suprloco_rom_region_decode.sv | 50 +++++
 rtl/suprloco_rom_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/suprloco_loader_pkg.sv
// Shared types and default ROM map for the SuprLoco ROM loader.
package suprloco_loader_pkg;

    // ROM regions of the board's write port, in address order
    typedef enum logic [2:0] {
        REG_MAIN = 3'd0,
        REG_SND  = 3'd1,
        REG_TILE = 3'd2,
        REG_SPR  = 3'd3,
        REG_PROM = 3'd4
    } region_e;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD
    } state_e;

    // Exclusive end address of each region in the download image
    localparam logic [23:0] DEF_MAIN_END = 24'h00C000;
    localparam logic [23:0] DEF_SND_END  = 24'h00E000;
    localparam logic [23:0] DEF_TILE_END = 24'h014000;
    localparam logic [23:0] DEF_SPR_END  = 24'h01C000;
    localparam logic [23:0] DEF_PROM_END = 24'h01C200;

endpackage

// File: rtl/suprloco_rom_region_decode.sv
// Maps a download byte address onto a ROM region and the offset inside it.
module suprloco_rom_region_decode
    import suprloco_loader_pkg::*;
#(
    parameter logic [23:0] MAIN_END = DEF_MAIN_END,
    parameter logic [23:0] SND_END  = DEF_SND_END,
    parameter logic [23:0] TILE_END = DEF_TILE_END,
    parameter logic [23:0] SPR_END  = DEF_SPR_END,
    parameter logic [23:0] PROM_END = DEF_PROM_END
) (
    input  logic [26:0] addr,
    output logic        valid,
    output region_e     sel,
    output logic [16:0] offset
);

    logic [23:0] base;

    // Region lookup: anything with the top address bits set or past the PROM is off the map
    always_comb begin
        valid  = 1'b1;
        sel    = REG_MAIN;
        base   = 24'd0;
        offset = 17'd0;
        if (addr[26:24] != 3'd0) begin
            valid = 1'b0;
        end else if (addr[23:0] < MAIN_END) begin
            sel  = REG_MAIN;
            base = 24'd0;
        end else if (addr[23:0] < SND_END) begin
            sel  = REG_SND;
            base = MAIN_END;
        end else if (addr[23:0] < TILE_END) begin
            sel  = REG_TILE;
            base = SND_END;
        end else if (addr[23:0] < SPR_END) begin
            sel  = REG_SPR;
            base = TILE_END;
        end else if (addr[23:0] < PROM_END) begin
            sel  = REG_PROM;
            base = SPR_END;
        end else begin
            valid = 1'b0;
        end
        if (valid) begin
            offset = 17'(addr[23:0] - base);
        end
    end

endmodule

// File: rtl/suprloco_rom_loader.sv
// Bridges the HPS ioctl download stream to the SuprLoco board ROM write port,
// captures DIP switches and sequences the board reset around a ROM download.
module suprloco_rom_loader
    import suprloco_loader_pkg::*;
#(
    parameter logic [23:0] MAIN_END  = DEF_MAIN_END,
    parameter logic [23:0] SND_END   = DEF_SND_END,
    parameter logic [23:0] TILE_END  = DEF_TILE_END,
    parameter logic [23:0] SPR_END   = DEF_SPR_END,
    parameter logic [23:0] PROM_END  = DEF_PROM_END,
    parameter int          RST_HOLD  = 16,
    parameter logic [7:0]  ROM_INDEX = 8'd0,
    parameter logic [7:0]  DIP_INDEX = 8'd254
) (
    input  logic        i_EMU_MCLK,
    input  logic        i_EMU_INITRST,
    input  logic [15:0] ioctl_index,
    input  logic        ioctl_download,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic        o_ROM_REQ,
    output logic [2:0]  o_ROM_SEL,
    output logic [16:0] o_ROM_ADDR,
    output logic [7:0]  o_ROM_DATA,
    input  logic        i_ROM_ACK,
    output logic [23:0] o_DIPSW,
    output logic        o_CORE_RST,
    output logic        o_LOAD_DONE,
    output logic        o_LOAD_ERR
);

    localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_e            state;
    logic              rom_dl_q;
    logic              hold_pend;
    logic [23:0]       byte_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic              dec_valid;
    region_e           dec_sel;
    logic [16:0]       dec_offset;

    logic              is_rom;
    logic              is_dip;
    logic              rom_wr;
    logic              dip_wr;
    logic              rom_dl;
    logic              rom_rise;
    logic              rom_fall;
    logic              accept;
    logic              busy_next;
    logic              unused_index_hi;

    assign is_rom          = (ioctl_index[7:0] == ROM_INDEX);
    assign is_dip          = (ioctl_index[7:0] == DIP_INDEX);
    assign rom_wr          = ioctl_wr && is_rom;
    assign dip_wr          = ioctl_wr && is_dip;
    assign rom_dl          = ioctl_download && is_rom;
    assign rom_rise        = rom_dl && !rom_dl_q;
    assign rom_fall        = !rom_dl && rom_dl_q;
    assign accept          = (state == ST_IDLE) && rom_wr && dec_valid;
    // A request will still be outstanding after this edge, so HOLD must wait for it
    assign busy_next       = ((state == ST_REQ) && !i_ROM_ACK) || accept;
    assign unused_index_hi = ^ioctl_index[15:8];

    suprloco_rom_region_decode #(
        .MAIN_END (MAIN_END),
        .SND_END  (SND_END),
        .TILE_END (TILE_END),
        .SPR_END  (SPR_END),
        .PROM_END (PROM_END)
    ) u_decode (
        .addr   (ioctl_addr),
        .valid  (dec_valid),
        .sel    (dec_sel),
        .offset (dec_offset)
    );

    // Loader FSM: byte handshake, DIP capture, download bookkeeping and reset sequencing
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_INITRST) begin
            state       <= ST_IDLE;
            rom_dl_q    <= 1'b0;
            hold_pend   <= 1'b0;
            byte_cnt    <= 24'd0;
            hold_cnt    <= '0;
            ioctl_wait  <= 1'b0;
            o_ROM_REQ   <= 1'b0;
            o_ROM_SEL   <= 3'd0;
            o_ROM_ADDR  <= 17'd0;
            o_ROM_DATA  <= 8'd0;
            o_DIPSW     <= 24'hFFFFFF;
            o_CORE_RST  <= 1'b1;
            o_LOAD_DONE <= 1'b0;
            o_LOAD_ERR  <= 1'b0;
        end else begin
            rom_dl_q <= rom_dl;

            if (dip_wr) begin
                if (ioctl_addr == 27'd0) begin
                    o_DIPSW[7:0] <= ioctl_data;
                end else if (ioctl_addr == 27'd1) begin
                    o_DIPSW[15:8] <= ioctl_data;
                end else if (ioctl_addr == 27'd2) begin
                    o_DIPSW[23:16] <= ioctl_data;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (rom_wr) begin
                        if (dec_valid) begin
                            o_ROM_SEL  <= dec_sel;
                            o_ROM_ADDR <= dec_offset;
                            o_ROM_DATA <= ioctl_data;
                            o_ROM_REQ  <= 1'b1;
                            ioctl_wait <= 1'b1;
                            byte_cnt   <= byte_cnt + 24'd1;
                            state      <= ST_REQ;
                        end else begin
                            o_LOAD_ERR <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // The HPS ignored ioctl_wait: the byte is lost
                    if (rom_wr) begin
                        o_LOAD_ERR <= 1'b1;
                    end
                    if (i_ROM_ACK) begin
                        o_ROM_REQ  <= 1'b0;
                        ioctl_wait <= 1'b0;
                        if (hold_pend) begin
                            hold_pend <= 1'b0;
                            hold_cnt  <= '0;
                            state     <= ST_HOLD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rom_wr) begin
                        o_LOAD_ERR <= 1'b1;
                    end
                    if (hold_cnt == HOLD_LAST) begin
                        o_CORE_RST <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (rom_fall) begin
                if ((byte_cnt == PROM_END) && !o_LOAD_ERR) begin
                    o_LOAD_DONE <= 1'b1;
                end else begin
                    o_LOAD_ERR <= 1'b1;
                end
                if (busy_next) begin
                    hold_pend <= 1'b1;
                end else begin
                    hold_cnt <= '0;
                    state    <= ST_HOLD;
                end
            end

            if (rom_rise) begin
                o_LOAD_DONE <= 1'b0;
                o_LOAD_ERR  <= 1'b0;
                byte_cnt    <= 24'd0;
                hold_pend   <= 1'b0;
                if (state == ST_HOLD) begin
                    state <= ST_IDLE;
                end
            end

            if (rom_dl) begin
                o_CORE_RST <= 1'b1;
            end
        end
    end

endmodule
